wb_dshot_decoder: RTL and testbench

Single-channel DSHOT receiver with a Wishbone B3 slave interface. It is the receive-side counterpart of the 4-channel DSHOT motor controller.
It samples a DSHOT line, classifies each bit by its high-pulse width, and assembles 16-bit frames. It then checks the 4-bit CRC and publishes good frames and error statistics through registers.
Used for motor-output loopback self-test and for sniffing an external flight controller on the shared DSHOT line.

---
 rtl/wb_dshot_decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_wb_dshot_decoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dshot_decoder.sv
// Single-channel DSHOT receiver: classifies bits by high-pulse width, assembles
// 16-bit frames, checks the 4-bit CRC and reports frames/errors over Wishbone.
module wb_dshot_decoder #(
    parameter int CLK_FREQ_HZ  = 72_000_000,
    parameter int DEFAULT_MODE = 150
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_dat_i,
    input  logic [31:0] wb_adr_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    input  logic        dshot_rx,
    output logic [15:0] frame_o,
    output logic        frame_valid_o,
    output logic        err_o,
    output logic [2:0]  dbg_state
);

    localparam int CW = $clog2(2 * (CLK_FREQ_HZ / 150_000) + 1);
    localparam logic [CW-1:0] T150 = CW'(CLK_FREQ_HZ / 150_000);
    localparam logic [CW-1:0] T300 = CW'(CLK_FREQ_HZ / 300_000);
    localparam logic [CW-1:0] T600 = CW'(CLK_FREQ_HZ / 600_000);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MEAS_HIGH = 3'd1,
        MEAS_LOW  = 3'd2,
        CHECK     = 3'd3,
        RESYNC    = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n, cnt_inc;
    logic [CW-1:0]   tbit, tbit_n, t_half, t_min, t_two, mode_tbit;
    logic [4:0]      bit_idx, bit_idx_n;
    logic [15:0]     shift, shift_n;
    logic            rx_s1, rx_s2, rx_d, rise, fall;
    logic            good_ev, crc_ev, frm_ev, crc_ok;

    logic [15:0]     mode, good_cnt, err_cnt;
    logic            new_flag, overrun, crc_err, framing_err;
    logic            acc, wr, rd;
    logic [3:0]      word;
    logic [31:0]     rdata;
    logic            unused_bits;

    assign wb_stall_o  = 1'b0;
    assign dbg_state   = state;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:16]};

    // Handshake: ack follows each access (cyc & stb while ack low) by one
    // cycle; read data and all side effects are taken on that access cycle.
    assign acc  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr   = acc & wb_we_i;
    assign rd   = acc & ~wb_we_i;
    assign word = wb_adr_i[5:2];

    assign rise = rx_s2 & ~rx_d;
    assign fall = ~rx_s2 & rx_d;

    always_comb begin
        case (mode)
            16'd300: mode_tbit = T300;
            16'd600: mode_tbit = T600;
            default: mode_tbit = T150;
        endcase
    end

    assign t_half  = tbit >> 1;
    assign t_min   = tbit >> 3;
    assign t_two   = {tbit[CW-2:0], 1'b0};
    assign cnt_inc = cnt + CW'(1);
    assign crc_ok  = (shift[7:4] ^ shift[11:8] ^ shift[15:12]) == shift[3:0];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_s1   <= 1'b0;
            rx_s2   <= 1'b0;
            rx_d    <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            tbit    <= T150;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            rx_s1   <= dshot_rx;
            rx_s2   <= rx_s1;
            rx_d    <= rx_s2;
            state   <= state_n;
            cnt     <= cnt_n;
            tbit    <= tbit_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        tbit_n    = tbit;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        good_ev   = 1'b0;
        crc_ev    = 1'b0;
        frm_ev    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n   = MEAS_HIGH;
                    cnt_n     = CW'(1);
                    bit_idx_n = '0;
                    shift_n   = '0;
                    tbit_n    = mode_tbit;
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    if (cnt < t_min) begin
                        frm_ev  = 1'b1;
                        state_n = RESYNC;
                        cnt_n   = CW'(1);
                    end else begin
                        shift_n   = {shift[14:0], (cnt >= t_half)};
                        bit_idx_n = bit_idx + 5'd1;
                        if (bit_idx == 5'd15) begin
                            state_n = CHECK;
                        end else begin
                            state_n = MEAS_LOW;
                            cnt_n   = CW'(1);
                        end
                    end
                end else if (cnt_inc == tbit) begin
                    frm_ev  = 1'b1;
                    state_n = RESYNC;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    state_n = MEAS_HIGH;
                    cnt_n   = CW'(1);
                end else if (cnt_inc == t_two) begin
                    frm_ev  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            CHECK: begin
                good_ev = crc_ok;
                crc_ev  = ~crc_ok;
                state_n = IDLE;
            end
            RESYNC: begin
                // Only a continuous low stretch of two bit periods re-arms the receiver.
                if (rx_s2) begin
                    cnt_n = '0;
                end else if (cnt_inc == t_two) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (word)
            4'd0:    rdata = {15'b0, new_flag, frame_o};
            4'd1:    rdata = {28'b0, framing_err, crc_err, overrun, new_flag};
            4'd2:    rdata = {16'b0, mode};
            4'd3:    rdata = {err_cnt, good_cnt};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o      <= 1'b0;
            wb_dat_o      <= '0;
            frame_o       <= '0;
            frame_valid_o <= 1'b0;
            err_o         <= 1'b0;
            new_flag      <= 1'b0;
            overrun       <= 1'b0;
            crc_err       <= 1'b0;
            framing_err   <= 1'b0;
            mode          <= 16'(DEFAULT_MODE);
            good_cnt      <= '0;
            err_cnt       <= '0;
        end else begin
            wb_ack_o      <= acc;
            if (acc) wb_dat_o <= rdata;
            frame_valid_o <= good_ev;
            err_o         <= crc_ev | frm_ev;
            if (good_ev) frame_o <= shift;

            // Hardware set events win over software clears in the same cycle.
            if (good_ev)                 new_flag <= 1'b1;
            else if (rd && word == 4'd0) new_flag <= 1'b0;

            if (good_ev && new_flag)                        overrun <= 1'b1;
            else if (wr && word == 4'd1 && wb_dat_i[1])     overrun <= 1'b0;
            if (crc_ev)                                     crc_err <= 1'b1;
            else if (wr && word == 4'd1 && wb_dat_i[2])     crc_err <= 1'b0;
            if (frm_ev)                                     framing_err <= 1'b1;
            else if (wr && word == 4'd1 && wb_dat_i[3])     framing_err <= 1'b0;

            if (wr && word == 4'd2) mode <= wb_dat_i[15:0];

            if (wr && word == 4'd3) begin
                good_cnt <= {15'b0, good_ev};
                err_cnt  <= {15'b0, crc_ev | frm_ev};
            end else begin
                if (good_ev && good_cnt != 16'hFFFF)           good_cnt <= good_cnt + 16'd1;
                if ((crc_ev | frm_ev) && err_cnt != 16'hFFFF)  err_cnt  <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_dshot_decoder.sv
// Bench for wb_dshot_decoder: directed and randomized DSHOT frames checked
// against a register-level model of the receiver.
module tb_wb_dshot_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_adr_i = '0;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'hF;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_stall_o;
    logic        dshot_rx = 1'b0;
    logic [15:0] frame_o;
    logic        frame_valid_o;
    logic        err_o;
    logic [2:0]  dbg_state;

    wb_dshot_decoder #(.CLK_FREQ_HZ(72_000_000), .DEFAULT_MODE(150)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_dat_i(wb_dat_i), .wb_adr_i(wb_adr_i),
        .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
        .dshot_rx(dshot_rx), .frame_o(frame_o), .frame_valid_o(frame_valid_o),
        .err_o(err_o), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] exp_q[$];
    logic [15:0] m_frame;
    logic [15:0] m_mode;
    bit          m_new, m_ovr, m_crc, m_frm;
    int          m_good, m_err, m_err_pulses;

    function automatic logic [3:0] crc4(input logic [11:0] d);
        logic [11:0] x;
        x = d ^ (d >> 4) ^ (d >> 8);
        return x[3:0];
    endfunction

    function automatic int period_of(input logic [15:0] mode);
        int m;
        m = (mode == 16'd300 || mode == 16'd600) ? int'(mode) : 150;
        return 72_000_000 / (m * 1000);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_frame = '0; m_mode = 16'd150;
        m_new = 0; m_ovr = 0; m_crc = 0; m_frm = 0;
        m_good = 0; m_err = 0; m_err_pulses = 0;
    endtask

    task automatic model_frame(input logic [15:0] f);
        if (crc4(f[15:4]) == f[3:0]) begin
            exp_q.push_back(f);
            if (m_new) m_ovr = 1;
            m_new = 1;
            m_frame = f;
            if (m_good < 65535) m_good++;
        end else begin
            m_crc = 1;
            if (m_err < 65535) m_err++;
            m_err_pulses++;
        end
    endtask

    task automatic model_framing();
        m_frm = 1;
        if (m_err < 65535) m_err++;
        m_err_pulses++;
    endtask

    // ---------------- output monitor ----------------
    logic [15:0] obs_q[$];
    int          err_pulses = 0;
    int          obs_rd = 0;

    always @(negedge clk) begin
        if (rst) begin
            obs_q.delete();
            err_pulses <= 0;
        end else begin
            if (frame_valid_o) obs_q.push_back(frame_o);
            if (err_o) err_pulses <= err_pulses + 1;
        end
    end

    // ---------------- drivers ----------------
    task automatic line(input logic v, input int n);
        dshot_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [15:0] f, input int nbits, input int period, input bit exact);
        int w;
        for (int i = 0; i < nbits; i++) begin
            if (f[15-i])
                w = exact ? (period * 3) / 4 : $urandom_range((period * 7) / 8, (period * 5) / 8);
            else
                w = exact ? (period * 3) / 8 : $urandom_range((period * 3) / 8, period / 4);
            line(1'b1, w);
            line(1'b0, period - w);
        end
    endtask

    task automatic wb_cycle(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                            output logic [31:0] rdata);
        int n;
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(negedge clk);
        n = 1;
        while (!wb_ack_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_eq("wb_ack", {31'b0, wb_ack_o}, 32'd1);
        rdata = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] r;
        wb_cycle(adr, 1'b1, dat, r);
    endtask

    task automatic check_reg(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        wb_cycle(adr, 1'b0, '0, r);
        check_eq(tag, r, exp);
    endtask

    task automatic check_rx_frame(input string tag);
        check_reg(tag, 32'h00, {15'b0, m_new, m_frame});
        m_new = 0;
    endtask

    task automatic check_status(input string tag);
        check_reg(tag, 32'h04, {28'b0, m_frm, m_crc, m_ovr, m_new});
    endtask

    task automatic check_counts(input string tag);
        check_reg(tag, 32'h0C, {m_err[15:0], m_good[15:0]});
    endtask

    task automatic set_mode(input logic [15:0] m);
        wb_write(32'h08, {16'hA5A5, m});
        m_mode = m;
        check_reg("config", 32'h08, {16'b0, m});
    endtask

    task automatic compare_outputs(input string tag);
        check_eq({tag, "_valid_pulses"}, obs_q.size() - obs_rd, exp_q.size());
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            check_eq({tag, "_frame"}, {16'b0, obs_q[obs_rd]}, {16'b0, exp_q.pop_front()});
            obs_rd++;
        end
        exp_q.delete();
        obs_rd = obs_q.size();
        check_eq({tag, "_frame_o"}, {16'b0, frame_o}, {16'b0, m_frame});
        check_eq({tag, "_err_pulses"}, err_pulses, m_err_pulses);
    endtask

    task automatic deliver(input string tag, input logic [15:0] f, input bit exact);
        send_bits(f, 16, period_of(m_mode), exact);
        line(1'b0, 16);
        model_frame(f);
        compare_outputs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        model_reset();
        obs_rd = 0;
        @(negedge clk);
    endtask

    function automatic logic [15:0] make_frame(input bit good);
        logic [11:0] d;
        logic [3:0]  c;
        d = 12'($urandom_range(0, 4095));
        c = crc4(d);
        if (!good) c = c ^ 4'($urandom_range(1, 15));
        return {d, c};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] f;
        logic [15:0] modes[4];
        modes[0] = 16'd150; modes[1] = 16'd300; modes[2] = 16'd600; modes[3] = 16'd1234;

        do_reset();
        check_eq("rst_frame_o", {16'b0, frame_o}, 32'd0);
        check_eq("rst_valid", {31'b0, frame_valid_o}, 32'd0);
        check_eq("rst_err", {31'b0, err_o}, 32'd0);
        check_reg("rst_rx_frame", 32'h00, 32'd0);
        check_reg("rst_status", 32'h04, 32'd0);
        check_reg("rst_config", 32'h08, 32'd150);
        check_reg("rst_counts", 32'h0C, 32'd0);
        check_reg("unmapped", 32'h10, 32'd0);

        // DSHOT150 directed frame
        deliver("f7d0a", 16'h7D0A, 1);
        check_rx_frame("rx_frame_first");
        check_counts("counts_one");
        check_rx_frame("rx_frame_reread");

        // DSHOT600 good then bad CRC, W1C of crc_err
        set_mode(16'd600);
        deliver("f0606", 16'h0606, 1);
        deliver("f7d0b", 16'h7D0B, 1);
        check_status("status_crc");
        wb_write(32'h04, 32'h4);
        m_crc = 0;
        check_status("status_crc_clr");

        // Overrun: two good frames without reading
        check_rx_frame("rx_frame_pre_ovr");
        deliver("ovr_a", make_frame(1), 0);
        deliver("ovr_b", make_frame(1), 0);
        check_status("status_ovr");
        check_rx_frame("rx_frame_ovr");

        // DSHOT300 truncated frame, then a short glitch, then a good frame
        set_mode(16'd300);
        send_bits(make_frame(1), 10, 240, 0);
        line(1'b0, 480);
        model_framing();
        compare_outputs("trunc");
        check_status("status_trunc");
        line(1'b1, 20);
        line(1'b0, 600);
        model_framing();
        compare_outputs("glitch");
        deliver("after_glitch", make_frame(1), 0);
        check_counts("counts_glitch");
        wb_write(32'h04, 32'hE);
        m_ovr = 0; m_crc = 0; m_frm = 0;
        check_status("status_w1c_all");

        // Reset in the middle of a frame
        send_bits(make_frame(1), 8, 240, 0);
        do_reset();
        check_reg("rst_mid_config", 32'h08, 32'd150);
        deliver("post_rst", make_frame(1), 0);
        check_counts("counts_post_rst");

        // Randomized traffic
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 2) == 0) set_mode(modes[$urandom_range(0, 3)]);
            f = make_frame($urandom_range(0, 3) != 0);
            deliver("rand", f, 0);
            if ($urandom_range(0, 1) == 1) check_rx_frame("rand_rx_frame");
            check_status("rand_status");
            check_counts("rand_counts");
            if ($urandom_range(0, 5) == 0) begin
                wb_write(32'h0C, $urandom);
                m_good = 0; m_err = 0;
            end
        end
        check_counts("final_counts");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
